// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: operand class, IEEE-754 binary32 limits, divider latency.
package fpu_pkg;

    typedef enum logic [1:0] {
        ClsNorm = 2'd0,
        ClsZero = 2'd1,
        ClsInf  = 2'd2,
        ClsNan  = 2'd3
    } cls_e;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam int unsigned LAT_CORE = 10;

    // Special-case class of x1 / x2 from the two exponent fields; denormals count as zero.
    function automatic cls_e div_classify(input logic [7:0] e1, input logic [7:0] e2);
        logic x1_zero;
        logic x2_zero;
        x1_zero = (e1 == 8'd0);
        x2_zero = (e2 == 8'd0);
        if (x1_zero && x2_zero) begin
            return ClsNan;
        end else if (x2_zero) begin
            return ClsInf;
        end else if (e1 == 8'hFF) begin
            return ClsInf;
        end else if (x1_zero || e2 == 8'hFF) begin
            return ClsZero;
        end
        return ClsNorm;
    endfunction

endpackage

// File: rtl/fdiv_mantissa.sv
// Pipelined restoring divider: quotient = floor(ma * 2^25 / mb), 26 bits over LAT_CORE stages.
module fdiv_mantissa
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        input_valid,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [25:0] quotient,
    output logic        out_valid
);

    // Six 3-bit stages then four 2-bit stages resolve all 26 quotient bits, MSB first.
    for (genvar i = 0; i < LAT_CORE; i++) begin : g_stage
        localparam int NBits = (i < 6) ? 3 : 2;
        localparam int First = (i < 6) ? 3 * i : 18 + 2 * (i - 6);

        logic [24:0] rem_in, rem_d, rem_q;
        logic [25:0] quo_in, quo_d, quo_q;
        logic [23:0] div_in, div_q;
        logic        vld_in, vld_q;

        if (i == 0) begin : g_head
            assign rem_in = {1'b0, ma};
            assign quo_in = '0;
            assign div_in = mb;
            assign vld_in = input_valid;
        end else begin : g_body
            assign rem_in = g_stage[i-1].rem_q;
            assign quo_in = g_stage[i-1].quo_q;
            assign div_in = g_stage[i-1].div_q;
            assign vld_in = g_stage[i-1].vld_q;
        end

        // Remainder stays below 2*mb, so 25 bits hold it across every shift.
        always_comb begin
            rem_d = rem_in;
            quo_d = quo_in;
            for (int b = 0; b < NBits; b++) begin
                if (rem_d >= {1'b0, div_in}) begin
                    quo_d[25 - (First + b)] = 1'b1;
                    rem_d = rem_d - {1'b0, div_in};
                end
                rem_d = rem_d << 1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                rem_q <= '0;
                quo_q <= '0;
                div_q <= '0;
            end else begin
                vld_q <= vld_in;
                rem_q <= rem_d;
                quo_q <= quo_d;
                div_q <= div_in;
            end
        end
    end

    assign quotient  = g_stage[LAT_CORE-1].quo_q;
    assign out_valid = g_stage[LAT_CORE-1].vld_q;

endmodule

// File: rtl/fdiv.sv
// Single-precision divider y = x1 / x2: mantissa core plus matched sign/exponent/class pipeline,
// then normalize, round half-up on the guard bit and pack.
module fdiv
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_valid,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        out_valid
);

    localparam logic signed [EXP_W-1:0] ExpBias = EXP_W'(EXP_BIAS);
    localparam logic signed [EXP_W-1:0] ExpMax  = EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W-1:0] ExpOne  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] ExpZero = '0;

    logic        rst_n;
    logic [23:0] ma, mb;
    logic [25:0] quotient;
    logic        core_valid;

    assign rst_n = ~rst;
    assign ma    = {1'b1, x1[22:0]};
    assign mb    = {1'b1, x2[22:0]};

    fdiv_mantissa u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_valid (input_valid),
        .ma          (ma),
        .mb          (mb),
        .quotient    (quotient),
        .out_valid   (core_valid)
    );

    logic                    s_d;
    logic signed [EXP_W-1:0] e1_ext, e2_ext, e_d;
    cls_e                    cls_d;

    assign s_d    = x1[31] ^ x2[31];
    assign e1_ext = {{(EXP_W-8){1'b0}}, x1[30:23]};
    assign e2_ext = {{(EXP_W-8){1'b0}}, x2[30:23]};
    assign e_d    = e1_ext - e2_ext + ExpBias;
    assign cls_d  = div_classify(x1[30:23], x2[30:23]);

    logic                    s_q   [LAT_CORE];
    logic signed [EXP_W-1:0] e_q   [LAT_CORE];
    cls_e                    cls_q [LAT_CORE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT_CORE; i++) begin
                s_q[i]   <= 1'b0;
                e_q[i]   <= '0;
                cls_q[i] <= ClsNorm;
            end
        end else begin
            s_q[0]   <= s_d;
            e_q[0]   <= e_d;
            cls_q[0] <= cls_d;
            for (int i = 1; i < LAT_CORE; i++) begin
                s_q[i]   <= s_q[i-1];
                e_q[i]   <= e_q[i-1];
                cls_q[i] <= cls_q[i-1];
            end
        end
    end

    logic                    s_o;
    cls_e                    cls_o;
    logic [22:0]             frac;
    logic                    guard;
    logic [23:0]             frac_rnd;
    logic signed [EXP_W-1:0] exp_n;
    logic [31:0]             y_d;

    always_comb begin
        s_o   = s_q[LAT_CORE-1];
        cls_o = cls_q[LAT_CORE-1];
        if (quotient[25]) begin
            frac  = quotient[24:2];
            guard = quotient[1];
            exp_n = e_q[LAT_CORE-1];
        end else begin
            frac  = quotient[23:1];
            guard = quotient[0];
            exp_n = e_q[LAT_CORE-1] - ExpOne;
        end
        // A carry out of the fraction leaves frac_rnd[22:0] = 0 and bumps the exponent.
        frac_rnd = {1'b0, frac} + 24'(guard);
        if (frac_rnd[23]) begin
            exp_n = exp_n + ExpOne;
        end

        if (exp_n >= ExpMax) begin
            y_d = {s_o, 8'hFF, 23'd0};
        end else if (exp_n <= ExpZero) begin
            y_d = {s_o, 31'd0};
        end else begin
            y_d = {s_o, exp_n[7:0], frac_rnd[22:0]};
        end

        unique case (cls_o)
            ClsZero: y_d = {s_o, 31'd0};
            ClsInf:  y_d = {s_o, 8'hFF, 23'd0};
            ClsNan:  y_d = QNAN;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= core_valid;
            if (core_valid) begin
                y <= y_d;
            end
        end
    end

endmodule

// File: doc/fdiv.md
Name: fdiv

Overview:
- Single-precision floating-point divider, y = x1 / x2, fully pipelined with a valid-only handshake.
- Unpacks both operands and feeds the hidden-bit mantissas to the existing 10-stage mantissa divider core (fdiv_mantissa).
- Carries sign, exponent and special-case class alongside the core in a matched side pipeline, then normalizes, rounds and packs the result.
- Sits in the FPU next to fadd/fmul and is driven by the FPU issue logic.

Parameters:
- LAT_CORE, 10, mantissa-core latency in cycles; side-pipeline depth; fixed to match the core.
- EXP_W, 10, signed width of the intermediate exponent.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_valid  in  1  operands valid this cycle. No backpressure: accepted every cycle.
- x1  in  32  dividend, IEEE-754 binary32.
- x2  in  32  divisor, IEEE-754 binary32.
- y  out  32  quotient, registered.
- out_valid  out  1  y valid this cycle, registered.

Behaviour:
- Reset:
  - y=0, out_valid=0; all side-pipeline valid/class bits = 0.
  - The core is driven with rst_n = ~rst.
  - Reset mid-operation discards every in-flight op; no out_valid until new inputs arrive.
- Unpack (combinational, into core inputs):
  - ma = {1, x1[22:0]}, mb = {1, x2[22:0]}.
  - Exponent field 0 is treated as zero (denormals flushed).
- Core contract:
  - quotient = floor(ma·2^25 / mb), 26 bits.
  - quotient[25]=1 iff ma >= mb; otherwise quotient[24]=1.
  - Core out_valid asserts exactly LAT_CORE cycles after input_valid.
- Side pipeline, LAT_CORE stages, captured at the same edge as the core:
  - s = x1[31] ^ x2[31].
  - e = e1 - e2 + 127, EXP_W-bit signed.
  - cls = NORM / ZERO / INF / NAN:
    - x2 zero and x1 zero → NAN
    - x2 zero → INF
    - x1 exponent 255 → INF
    - x1 zero or x2 exponent 255 → ZERO
    - else NORM
- Output stage (registered one cycle after core out_valid; total latency 11: sample at edge 0, y valid after edge 11):
  - If quotient[25]=1: frac = q[24:2], guard = q[1], exp = e.
  - If quotient[25]=0: frac = q[23:1], guard = q[0], exp = e-1.
  - Rounding is round-half-up on guard. No sticky bit is available; the error bound is ≤ 1 ulp.
  - If frac = all-ones and it rounds up: frac = 0, exp += 1.
  - exp >= 255 → ±inf (s, 0xFF, 0). exp <= 0 → ±0.
  - cls overrides the arithmetic result:
    - ZERO → {s, 31'b0}
    - INF → {s, 0xFF, 23'b0}
    - NAN → 0x7FC00000
- Throughput: one op per cycle. Back-to-back ops retire in order, one per cycle, with no bubbles.

Decomposition:
- fpu_pkg holds:
  - the class enum {NORM, ZERO, INF, NAN};
  - constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, LAT_CORE.
- Instantiates fdiv_mantissa unchanged as the only sub-module.
- Side pipeline and unpack/pack logic are local.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) → y = 0x40400000, out_valid exactly 11 cycles after input_valid.
- 0x3F800000 / 0x40400000 (1/3) → y = 0x3EAAAAAB (quotient 0x1555555, guard rounds up).
- 0x3F800000 / 0x00000000 → 0x7F800000; 0xBF800000 / 0x00000000 → 0xFF800000; 0 / 0 → 0x7FC00000.
- 0x7F000000 / 0x3F000000 → overflow 0x7F800000; 0x00800000 / 0x4B000000 → underflow 0x00000000.
- 12 consecutive valid ops of random normals, then a 3-cycle gap, then 2 more → out_valid pattern identical to the input pattern delayed 11 cycles. Each y must be within 1 ulp of the reference model.
- Assert rst while 5 ops are in flight → out_valid stays 0 for the next 11 cycles; the first post-reset op returns correctly after 11 cycles.
